// File: rtl/cca_ch_idle_gen.sv
// Clear-channel assessment: RSSI moving average, hysteresis energy detect, and
// busy/TX/hold tracking that produces the ch_idle level plus a busy-time counter.
module cca_ch_idle_gen #(
  parameter int unsigned RSSI_HALF_DB_WIDTH = 11,
  parameter int unsigned AVG_LOG2           = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          tsf_pulse_1M,
  input  logic [RSSI_HALF_DB_WIDTH-1:0] rssi_half_db,
  input  logic                          rssi_half_db_valid,
  input  logic [RSSI_HALF_DB_WIDTH-1:0] rssi_th,
  input  logic [7:0]                    rssi_hyst,
  input  logic                          demod_is_ongoing,
  input  logic                          tx_rf_active,
  input  logic [7:0]                    tx_tail_time,
  input  logic [7:0]                    busy_hold_time,
  input  logic                          force_idle,
  input  logic                          force_busy,
  input  logic                          busy_time_clear,
  output logic                          ch_idle,
  output logic [RSSI_HALF_DB_WIDTH-1:0] rssi_avg,
  output logic                          energy_busy,
  output logic [31:0]                   busy_time_us
);

  localparam int unsigned W     = RSSI_HALF_DB_WIDTH;
  localparam int unsigned WIN   = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = W + AVG_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_TX   = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  logic [W-1:0]        buf_mem [WIN];
  logic [AVG_LOG2-1:0] wptr;
  logic [SUM_W-1:0]    sum;
  logic [W:0]          avg_plus_hyst;
  logic                busy_raw;
  state_t              state;
  state_t              state_nxt;
  logic [7:0]          hold_cnt;
  logic [7:0]          hold_nxt;

  // Running sum over a circular window: add the new sample, drop the oldest.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < WIN; i++) begin
        buf_mem[AVG_LOG2'(i)] <= '0;
      end
      wptr <= '0;
      sum  <= '0;
    end else if (rssi_half_db_valid) begin
      sum           <= sum + SUM_W'(rssi_half_db) - SUM_W'(buf_mem[wptr]);
      buf_mem[wptr] <= rssi_half_db;
      wptr          <= wptr + AVG_LOG2'(1);
    end
  end

  assign rssi_avg = W'(sum >> AVG_LOG2);

  // One extra bit so avg + hyst cannot wrap below the threshold.
  assign avg_plus_hyst = {1'b0, rssi_avg} + (W+1)'(rssi_hyst);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      energy_busy <= 1'b0;
    end else if (rssi_avg >= rssi_th) begin
      energy_busy <= 1'b1;
    end else if (avg_plus_hyst < {1'b0, rssi_th}) begin
      energy_busy <= 1'b0;
    end
  end

  assign busy_raw = energy_busy || demod_is_ongoing;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Own transmission always dominates; tails are reloaded fresh on every exit.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      S_IDLE: begin
        if (tx_rf_active) begin
          state_nxt = S_TX;
        end else if (busy_raw) begin
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (tx_rf_active) begin
          state_nxt = S_TX;
        end else if (!busy_raw) begin
          state_nxt = S_HOLD;
          hold_nxt  = busy_hold_time;
        end
      end
      S_TX: begin
        if (!tx_rf_active) begin
          state_nxt = S_HOLD;
          hold_nxt  = tx_tail_time;
        end
      end
      S_HOLD: begin
        if (tx_rf_active) begin
          state_nxt = S_TX;
        end else if (busy_raw) begin
          state_nxt = S_BUSY;
        end else if (hold_cnt == 8'd0) begin
          state_nxt = S_IDLE;
        end else if (tsf_pulse_1M) begin
          hold_nxt = hold_cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ch_idle <= 1'b0;
    end else if (force_idle) begin
      ch_idle <= 1'b1;
    end else if (force_busy) begin
      ch_idle <= 1'b0;
    end else begin
      ch_idle <= (state == S_IDLE);
    end
  end

  // Saturating microsecond count of time the reported channel was busy.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_time_us <= '0;
    end else if (busy_time_clear) begin
      busy_time_us <= '0;
    end else if (tsf_pulse_1M && !ch_idle && (busy_time_us != 32'hFFFF_FFFF)) begin
      busy_time_us <= busy_time_us + 32'd1;
    end
  end

endmodule

// File: tb/tb_cca_ch_idle_gen.sv
// Scoreboard bench for cca_ch_idle_gen: directed scenarios plus random traffic
// checked cycle by cycle against a behavioural channel model.
module tb_cca_ch_idle_gen;

  localparam int W        = 11;
  localparam int AVG_LOG2 = 4;
  localparam int WIN      = 16;

  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_TX   = 2;
  localparam int M_HOLD = 3;

  logic         clk;
  logic         rstn;
  logic         tsf_pulse_1M;
  logic [W-1:0] rssi_half_db;
  logic         rssi_half_db_valid;
  logic [W-1:0] rssi_th;
  logic [7:0]   rssi_hyst;
  logic         demod_is_ongoing;
  logic         tx_rf_active;
  logic [7:0]   tx_tail_time;
  logic [7:0]   busy_hold_time;
  logic         force_idle;
  logic         force_busy;
  logic         busy_time_clear;
  logic         ch_idle;
  logic [W-1:0] rssi_avg;
  logic         energy_busy;
  logic [31:0]  busy_time_us;

  cca_ch_idle_gen #(.RSSI_HALF_DB_WIDTH(W), .AVG_LOG2(AVG_LOG2)) dut (
    .clk                (clk),
    .rstn               (rstn),
    .tsf_pulse_1M       (tsf_pulse_1M),
    .rssi_half_db       (rssi_half_db),
    .rssi_half_db_valid (rssi_half_db_valid),
    .rssi_th            (rssi_th),
    .rssi_hyst          (rssi_hyst),
    .demod_is_ongoing   (demod_is_ongoing),
    .tx_rf_active       (tx_rf_active),
    .tx_tail_time       (tx_tail_time),
    .busy_hold_time     (busy_hold_time),
    .force_idle         (force_idle),
    .force_busy         (force_busy),
    .busy_time_clear    (busy_time_clear),
    .ch_idle            (ch_idle),
    .rssi_avg           (rssi_avg),
    .energy_busy        (energy_busy),
    .busy_time_us       (busy_time_us)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     ch;
    int     avg;
    int     en;
    longint bt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int     hist[$];
  int     m_en;
  int     m_mode;
  int     m_tail;
  int     m_ch;
  longint m_bt;
  int     tick;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int hist_avg();
    int s = 0;
    foreach (hist[i]) s += hist[i];
    return s >> AVG_LOG2;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < WIN; i++) hist.push_back(0);
    m_en = 0; m_mode = M_IDLE; m_tail = 0; m_ch = 0; m_bt = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int     avg_now, en_n, mode_n, tail_n, ch_n, raw;
    longint bt_n;
    if (!rstn) begin
      model_reset();
      return;
    end
    avg_now = hist_avg();
    en_n = m_en;
    if (avg_now >= int'(rssi_th)) en_n = 1;
    else if (avg_now + int'(rssi_hyst) < int'(rssi_th)) en_n = 0;
    raw    = (m_en != 0 || demod_is_ongoing) ? 1 : 0;
    mode_n = m_mode;
    tail_n = m_tail;
    if (m_mode == M_IDLE) begin
      if (tx_rf_active) mode_n = M_TX;
      else if (raw != 0) mode_n = M_BUSY;
    end else if (m_mode == M_BUSY) begin
      if (tx_rf_active) mode_n = M_TX;
      else if (raw == 0) begin mode_n = M_HOLD; tail_n = int'(busy_hold_time); end
    end else if (m_mode == M_TX) begin
      if (!tx_rf_active) begin mode_n = M_HOLD; tail_n = int'(tx_tail_time); end
    end else begin
      if (tx_rf_active) mode_n = M_TX;
      else if (raw != 0) mode_n = M_BUSY;
      else if (m_tail == 0) mode_n = M_IDLE;
      else if (tsf_pulse_1M) tail_n = m_tail - 1;
    end
    if (force_idle) ch_n = 1;
    else if (force_busy) ch_n = 0;
    else ch_n = (m_mode == M_IDLE) ? 1 : 0;
    bt_n = m_bt;
    if (busy_time_clear) bt_n = 0;
    else if (tsf_pulse_1M && m_ch == 0 && m_bt != 64'hFFFF_FFFF) bt_n = m_bt + 1;
    if (rssi_half_db_valid) begin
      hist.push_back(int'(rssi_half_db));
      void'(hist.pop_front());
    end
    m_en = en_n; m_mode = mode_n; m_tail = tail_n; m_ch = ch_n; m_bt = bt_n;
  endtask

  // Issue the current inputs for one cycle and queue the expected response.
  task automatic step();
    exp_t e;
    model_edge();
    e.ch = m_ch; e.avg = hist_avg(); e.en = m_en; e.bt = m_bt;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic step_tsf(input int n);
    for (int i = 0; i < n; i++) begin
      tsf_pulse_1M = ((tick % 5) == 0);
      tick++;
      step();
    end
    tsf_pulse_1M = 1'b0;
  endtask

  task automatic samples(input int val, input int n);
    rssi_half_db       = W'(val);
    rssi_half_db_valid = 1'b1;
    step_tsf(n);
    rssi_half_db_valid = 1'b0;
  endtask

  // Monitor: compare every registered output just after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty at %0t: got no expectation, required one per cycle", $time);
      end else begin
        e = exp_q.pop_front();
        chk("ch_idle", longint'(ch_idle), longint'(e.ch));
        chk("rssi_avg", longint'(rssi_avg), longint'(e.avg));
        chk("energy_busy", longint'(energy_busy), longint'(e.en));
        chk("busy_time_us", longint'(busy_time_us), e.bt);
      end
    end
  end

  initial begin
    tick = 0;
    model_reset();
    rstn = 1'b0; tsf_pulse_1M = 1'b0; rssi_half_db = '0; rssi_half_db_valid = 1'b0;
    rssi_th = W'(100); rssi_hyst = 8'd6; demod_is_ongoing = 1'b0; tx_rf_active = 1'b0;
    tx_tail_time = 8'd3; busy_hold_time = 8'd5; force_idle = 1'b0; force_busy = 1'b0;
    busy_time_clear = 1'b0;

    // Reset release
    step_tsf(3);
    rstn = 1'b1;
    step_tsf(5);
    chk("idle_after_reset", longint'(ch_idle), 1);

    // Average ramp with 160 against threshold 100
    samples(160, 20);
    step_tsf(4);
    chk("avg_settled", longint'(rssi_avg), 160);
    chk("energy_set", longint'(energy_busy), 1);
    chk("busy_from_energy", longint'(ch_idle), 0);

    // Hysteresis: 97 holds busy, 93 releases into the post-busy hold
    samples(97, 16);
    step_tsf(10);
    chk("hyst_hold_busy", longint'(energy_busy), 1);
    samples(93, 16);
    step_tsf(60);
    chk("hyst_cleared", longint'(energy_busy), 0);
    chk("idle_after_hold", longint'(ch_idle), 1);

    // Own transmit with 3 us tail
    tx_rf_active = 1'b1;
    step_tsf(2);
    chk("tx_busy", longint'(ch_idle), 0);
    step_tsf(98);
    tx_rf_active = 1'b0;
    step_tsf(40);
    chk("tx_tail_done", longint'(ch_idle), 1);

    // Demod re-entry during hold restarts the hold from busy_hold_time
    demod_is_ongoing = 1'b1;
    step_tsf(3);
    demod_is_ongoing = 1'b0;
    step_tsf(8);
    demod_is_ongoing = 1'b1;
    step_tsf(2);
    demod_is_ongoing = 1'b0;
    step_tsf(50);

    // Both forces while energy busy: force_idle wins
    samples(160, 16);
    force_idle = 1'b1; force_busy = 1'b1;
    step_tsf(5);
    chk("force_both", longint'(ch_idle), 1);
    force_idle = 1'b0; force_busy = 1'b0;
    samples(0, 16);
    step_tsf(40);

    // force_busy with exactly 1000 tsf pulses
    force_busy = 1'b1; busy_time_clear = 1'b1; tsf_pulse_1M = 1'b0;
    step();
    busy_time_clear = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tsf_pulse_1M = 1'b1; step();
      tsf_pulse_1M = 1'b0; step();
    end
    step(); step();
    chk("busy_time_1000", longint'(busy_time_us), 1000);
    busy_time_clear = 1'b1;
    step();
    busy_time_clear = 1'b0;
    chk("busy_time_cleared", longint'(busy_time_us), 0);
    force_busy = 1'b0;
    step_tsf(10);

    // Random traffic with a mid-run reset
    for (int i = 0; i < 4000; i++) begin
      if ((i % 500) == 0) begin
        rssi_th        = W'($urandom_range(0, 200));
        rssi_hyst      = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 2) != 0) rssi_hyst = 8'($urandom_range(0, 20));
        busy_hold_time = 8'($urandom_range(0, 10));
        tx_tail_time   = 8'($urandom_range(0, 10));
      end
      rstn               = (i == 2000) ? 1'b0 : 1'b1;
      rssi_half_db_valid = 1'($urandom_range(0, 1));
      rssi_half_db       = W'($urandom_range(0, 300));
      tsf_pulse_1M       = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0)   demod_is_ongoing = ~demod_is_ongoing;
      if ($urandom_range(0, 39) == 0)  tx_rf_active     = ~tx_rf_active;
      if ($urandom_range(0, 99) == 0)  force_idle       = ~force_idle;
      if ($urandom_range(0, 99) == 0)  force_busy       = ~force_busy;
      busy_time_clear = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
